// File: rtl/vga_pixel_sequencer.sv
// Turns VGA timing strobes into pixel coordinates and a frame number, and realigns the sync lines with the shader output.
// Optional build macro VGA_PIXEL_SEQUENCER_TEST_PATTERN_EN replaces color_i with an 8-bar colour pattern.
module vga_pixel_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LATENCY     = 4,
    parameter int COLOR_WIDTH = 12,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   visible_i,
    input  logic                   pixel_i,
    input  logic                   new_frame_i,
    output logic [9:0]             x_o,
    output logic [9:0]             y_o,
    output logic [FRAME_WIDTH-1:0] frame_o,
    output logic                   pixel_valid_o,
    input  logic [COLOR_WIDTH-1:0] color_i,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [COLOR_WIDTH-1:0] rgb_o
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic new_frame_q;
    logic frame_rise;

    // Only the first cycle of the two-cycle new_frame_i window resyncs.
    assign frame_rise = new_frame_i & ~new_frame_q;

    // pixel_valid_o is a one-cycle strobe with no backpressure: the shader must accept every strobe.
    assign pixel_valid_o = pixel_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_frame_q <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            frame_o     <= '0;
        end else begin
            new_frame_q <= new_frame_i;
            if (frame_rise) begin
                frame_o <= frame_o + FRAME_WIDTH'(1);
                x_o     <= '0;
                y_o     <= '0;
            end else if (pixel_i) begin
                if (x_o == X_LAST) begin
                    x_o <= '0;
                    y_o <= (y_o == Y_LAST) ? 10'd0 : y_o + 10'd1;
                end else begin
                    x_o <= x_o + 10'd1;
                end
            end
        end
    end

    logic hsync_d   [LATENCY];
    logic vsync_d   [LATENCY];
    logic visible_d [LATENCY];

    // Free-running shift register so blanking stays aligned even while coordinates are untrusted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                hsync_d[i]   <= 1'b1;
                vsync_d[i]   <= 1'b1;
                visible_d[i] <= 1'b0;
            end
        end else begin
            hsync_d[0]   <= hsync_i;
            vsync_d[0]   <= vsync_i;
            visible_d[0] <= visible_i;
            for (int i = 1; i < LATENCY; i++) begin
                hsync_d[i]   <= hsync_d[i-1];
                vsync_d[i]   <= vsync_d[i-1];
                visible_d[i] <= visible_d[i-1];
            end
        end
    end

    logic [COLOR_WIDTH-1:0] pixel_color;

`ifdef VGA_PIXEL_SEQUENCER_TEST_PATTERN_EN
    localparam int NIB = COLOR_WIDTH / 3;

    logic [2:0] bar_d [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                bar_d[i] <= 3'd0;
            end
        end else begin
            bar_d[0] <= x_o[9:7];
            for (int i = 1; i < LATENCY; i++) begin
                bar_d[i] <= bar_d[i-1];
            end
        end
    end

    // Bar index bits 2/1/0 switch the R/G/B nibbles fully on or off.
    always_comb begin
        pixel_color = '0;
        pixel_color = COLOR_WIDTH'({{NIB{bar_d[LATENCY-1][2]}},
                                    {NIB{bar_d[LATENCY-1][1]}},
                                    {NIB{bar_d[LATENCY-1][0]}}});
    end
`else
    assign pixel_color = color_i;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            rgb_o   <= '0;
        end else begin
            hsync_o <= hsync_d[LATENCY-1];
            vsync_o <= vsync_d[LATENCY-1];
            rgb_o   <= visible_d[LATENCY-1] ? pixel_color : '0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_sequencer.sv
// Self-checking bench for vga_pixel_sequencer: coordinate/frame counters, resync priority, delay-line alignment and blanking.
module tb_vga_pixel_sequencer;

    localparam int L  = 4;
    localparam int HA = 640;
    localparam int VA = 8;
    localparam int FW = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hsync_i, vsync_i, visible_i, pixel_i, new_frame_i;
    logic [CW-1:0] color_i;
    logic [9:0]    x_o, y_o;
    logic [FW-1:0] frame_o;
    logic          pixel_valid_o, hsync_o, vsync_o;
    logic [CW-1:0] rgb_o;

    vga_pixel_sequencer #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LATENCY(L), .COLOR_WIDTH(CW), .FRAME_WIDTH(FW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .visible_i(visible_i), .pixel_i(pixel_i), .new_frame_i(new_frame_i),
        .x_o(x_o), .y_o(y_o), .frame_o(frame_o), .pixel_valid_o(pixel_valid_o),
        .color_i(color_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .rgb_o(rgb_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0]   coord_q [$];
    logic [CW+1:0] exp_q [$];

    logic [9:0]    ex, ey;
    logic [FW-1:0] ef;
    logic          nf_prev;

    function automatic logic [CW-1:0] bar_color(input logic [2:0] b);
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ex = '0;
        ey = '0;
        ef = '0;
        nf_prev = 1'b0;
    endtask

    task automatic set_idle();
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        visible_i = 1'b0;
        pixel_i = 1'b0;
        new_frame_i = 1'b0;
        color_i = '0;
    endtask

    task automatic drive_cycle(input logic pix, input logic nf);
        logic [19:0] exp_c;
        vectors++;
        if ({frame_o, y_o, x_o} !== {ef, ey, ex}) begin
            miscompares++;
            $display("FAIL state: got f=%0d y=%0d x=%0d, expected f=%0d y=%0d x=%0d",
                     frame_o, y_o, x_o, ef, ey, ex);
        end
        pixel_i = pix;
        new_frame_i = nf;
        #1;
        vectors++;
        if (pixel_valid_o !== pix) begin
            miscompares++;
            $display("FAIL pixel_valid: got %b, expected %b", pixel_valid_o, pix);
        end
        if (pix) begin
            coord_q.push_back({ey, ex});
            exp_c = coord_q.pop_front();
            vectors++;
            if ({y_o, x_o} !== exp_c) begin
                miscompares++;
                $display("FAIL strobe_coord: got y=%0d x=%0d, expected y=%0d x=%0d",
                         y_o, x_o, exp_c[19:10], exp_c[9:0]);
            end
        end
        if (nf && !nf_prev) begin
            ef = ef + 1'b1;
            ex = '0;
            ey = '0;
        end else if (pix) begin
            if (ex == 10'(HA - 1)) begin
                ex = '0;
                ey = (ey == 10'(VA - 1)) ? 10'd0 : ey + 10'd1;
            end else begin
                ex = ex + 10'd1;
            end
        end
        nf_prev = nf;
        step();
    endtask

    task automatic strobe_n(input int n);
        int done = 0;
        while (done < n) begin
            if ($urandom_range(0, 3) == 0) begin
                drive_cycle(1'b0, 1'b0);
            end else begin
                drive_cycle(1'b1, 1'b0);
                done++;
            end
        end
    endtask

    task automatic frame_pulse();
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({x_o, y_o, frame_o, rgb_o, hsync_o, vsync_o} !== {10'd0, 10'd0, {FW{1'b0}}, {CW{1'b0}}, 2'b11}) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d f=%0d rgb=%h hs=%b vs=%b, expected zeros and syncs high",
                     name, x_o, y_o, frame_o, rgb_o, hsync_o, vsync_o);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hsync_i = 1'($urandom_range(0, 1));
            vsync_i = 1'($urandom_range(0, 1));
            visible_i = 1'($urandom_range(0, 1));
            pixel_i = 1'($urandom_range(0, 1));
            new_frame_i = 1'($urandom_range(0, 1));
            color_i = CW'($urandom_range(0, 4095));
            step();
            check_reset_outputs("reset_hold");
        end
        set_idle();
        step();
        reset_n = 1'b1;
        model_reset();
        step();
        frame_pulse();
        vectors++;
        if (frame_o !== 8'd1) begin
            miscompares++;
            $display("FAIL first_frame: got %0d, expected 1", frame_o);
        end
    endtask

    task automatic test_line_wrap();
        strobe_n(5 * HA);
        vectors++;
        if ({y_o, x_o} !== {10'd5, 10'd0}) begin
            miscompares++;
            $display("FAIL line_start: got y=%0d x=%0d, expected y=5 x=0", y_o, x_o);
        end
        strobe_n(HA - 1);
        vectors++;
        if ({y_o, x_o} !== {10'd5, 10'd639}) begin
            miscompares++;
            $display("FAIL line_end: got y=%0d x=%0d, expected y=5 x=639", y_o, x_o);
        end
        strobe_n(1);
        vectors++;
        if ({y_o, x_o} !== {10'd6, 10'd0}) begin
            miscompares++;
            $display("FAIL line_wrap: got y=%0d x=%0d, expected y=6 x=0", y_o, x_o);
        end
        strobe_n(2 * HA);
        vectors++;
        if ({y_o, x_o} !== {10'd0, 10'd0}) begin
            miscompares++;
            $display("FAIL y_wrap: got y=%0d x=%0d, expected y=0 x=0", y_o, x_o);
        end
    endtask

    task automatic test_frame_resync();
        logic [FW-1:0] f0;
        strobe_n(3 * HA + 123);
        f0 = frame_o;
        drive_cycle(1'b0, 1'b1);
        vectors++;
        if ({frame_o, y_o, x_o} !== {f0 + 8'd1, 10'd0, 10'd0}) begin
            miscompares++;
            $display("FAIL resync: got f=%0d y=%0d x=%0d, expected f=%0d y=0 x=0", frame_o, y_o, x_o, f0 + 8'd1);
        end
        // Second high cycle must be ignored; a strobe there still advances x.
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if ({frame_o, x_o} !== {f0 + 8'd1, 10'd1}) begin
            miscompares++;
            $display("FAIL resync_second: got f=%0d x=%0d, expected f=%0d x=1", frame_o, x_o, f0 + 8'd1);
        end
        while (ef != 8'hFF) frame_pulse();
        frame_pulse();
        vectors++;
        if (frame_o !== 8'd0) begin
            miscompares++;
            $display("FAIL frame_wrap: got %0d, expected 0", frame_o);
        end
    endtask

    task automatic test_simultaneous();
        strobe_n(10);
        drive_cycle(1'b1, 1'b1);
        vectors++;
        if ({y_o, x_o} !== 20'd0) begin
            miscompares++;
            $display("FAIL simultaneous: got y=%0d x=%0d, expected y=0 x=0", y_o, x_o);
        end
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        strobe_n(37);
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        for (int i = 0; i < L + 2; i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        set_idle();
        check_reset_outputs("async_reset_hold");
        reset_n = 1'b1;
        model_reset();
        drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_latency();
        localparam int N = 64;
        localparam int M = N + L + 2;
        logic          h_a [M];
        logic          v_a [M];
        logic          vis_a [M];
        logic [CW-1:0] col_a [M];
        logic [CW-1:0] exp_rgb;
        logic [CW+1:0] exp_e;
        int            fall_cycle = -1;
        for (int c = 0; c < M; c++) begin
            h_a[c] = !(c >= 20 && c < 28);
            v_a[c] = (c < N) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            vis_a[c] = (c < N) ? 1'($urandom_range(0, 1)) : 1'b0;
            col_a[c] = (c % 3 == 0) ? 12'hABC : CW'($urandom_range(0, 4095));
        end
        vis_a[10] = 1'b1;
        col_a[10 + L] = 12'hABC;
        vis_a[11] = 1'b0;
        col_a[11 + L] = 12'hABC;
        pixel_i = 1'b0;
        new_frame_i = 1'b0;
        for (int c = 0; c < M; c++) begin
            if (fall_cycle < 0 && c > 0 && hsync_o === 1'b0) fall_cycle = c;
            if (c >= L + 1 && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                vectors++;
                if ({hsync_o, vsync_o, rgb_o} !== exp_e) begin
                    miscompares++;
                    $display("FAIL pipe cycle %0d: got hs=%b vs=%b rgb=%h, expected hs=%b vs=%b rgb=%h",
                             c, hsync_o, vsync_o, rgb_o, exp_e[CW+1], exp_e[CW], exp_e[CW-1:0]);
                end
            end
            hsync_i = h_a[c];
            vsync_i = v_a[c];
            visible_i = vis_a[c];
            color_i = col_a[c];
            if (c < N) begin
`ifdef VGA_PIXEL_SEQUENCER_TEST_PATTERN_EN
                exp_rgb = vis_a[c] ? bar_color(ex[9:7]) : '0;
`else
                exp_rgb = vis_a[c] ? col_a[c + L] : '0;
`endif
                exp_q.push_back({h_a[c], v_a[c], exp_rgb});
            end
            step();
        end
        vectors++;
        if (exp_q.size() != 0 || fall_cycle != 20 + L + 1) begin
            miscompares++;
            $display("FAIL hsync_latency: got fall at cycle %0d (left %0d), expected cycle %0d",
                     fall_cycle, exp_q.size(), 20 + L + 1);
        end
        set_idle();
        step();
    endtask

`ifdef VGA_PIXEL_SEQUENCER_TEST_PATTERN_EN
    task automatic test_pattern();
        frame_pulse();
        strobe_n(HA - 1);
        visible_i = 1'b1;
        color_i = 12'h123;
        step();
        visible_i = 1'b0;
        for (int i = 0; i < L; i++) step();
        vectors++;
        if (rgb_o !== 12'hF00) begin
            miscompares++;
            $display("FAIL pattern_bar4: got %h, expected f00", rgb_o);
        end
        set_idle();
        step();
    endtask
`endif

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_line_wrap();
        test_frame_resync();
        test_simultaneous();
        test_mid_reset();
        test_latency();
`ifdef VGA_PIXEL_SEQUENCER_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
